// File: rtl/sdram_cmd_pkg.sv
// Shared definitions for the SDRAM command scheduler: op codes, field offsets,
// FSM encoding and the command-word builder.
package sdram_cmd_pkg;

  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b11;
  localparam int         OP_LSB  = 30;
  localparam int         LEN_LSB = 26;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  // The op field always has its MSB set, so a command word is never zero.
  function automatic logic [31:0] build_cmd(input logic        is_wr,
                                            input logic [3:0]  len,
                                            input logic [25:0] addr);
    logic [31:0] w;
    w                 = '0;
    w[OP_LSB +: 2]    = is_wr ? OP_WR : OP_RD;
    w[LEN_LSB +: 4]   = len;
    w[25:0]           = addr;
    return w;
  endfunction

endpackage

// File: rtl/sdram_cmd_arbiter_rr_arb2.sv
// Two-request round-robin picker; combinational pick, last-grant register
// advanced only by the update strobe.
module rr_arb2 (
  input  logic wr_clk,
  input  logic reset_n,
  input  logic req_wr_i,
  input  logic req_rd_i,
  input  logic upd_i,
  input  logic upd_wr_i,
  output logic pick_vld_o,
  output logic pick_wr_o
);

  logic last_wr_q;

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n)   last_wr_q <= 1'b0;
    else if (upd_i) last_wr_q <= upd_wr_i;
  end

  assign pick_vld_o = req_wr_i | req_rd_i;
  // Write wins when alone, or when both ask and the read path went last.
  assign pick_wr_o  = req_wr_i & (~req_rd_i | ~last_wr_q);

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Schedules AXI write/read commands into one SDRAM-bound FIFO: arbitrate, push
// a command word, then len+1 data beats for writes; stalls on fifo_full.
module sdram_cmd_arbiter
  import sdram_cmd_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              wr_clk,
  input  logic              reset_n,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [LEN_W-1:0]  wr_req_len,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [LEN_W-1:0]  rd_req_len,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_data,
  output logic              busy,
  output logic              grant_wr
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic             grant_q, grant_d;
  logic             upd;
  logic             pick_vld, pick_wr;

  rr_arb2 u_rr (
    .wr_clk     (wr_clk),
    .reset_n    (reset_n),
    .req_wr_i   (wr_req_valid),
    .req_rd_i   (rd_req_valid),
    .upd_i      (upd),
    .upd_wr_i   (grant_q),
    .pick_vld_o (pick_vld),
    .pick_wr_o  (pick_wr)
  );

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB;
      beats_q <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beats_d       = beats_q;
    grant_d       = grant_q;
    upd           = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_data     = '0;
    wr_req_ready  = 1'b0;
    rd_req_ready  = 1'b0;
    wr_data_ready = 1'b0;
    unique case (state_q)
      ARB: begin
        if (pick_vld) begin
          grant_d = pick_wr;
          state_d = CMD;
        end
      end
      CMD: begin
        // Address/len are taken live; the requester holds them until ready.
        fifo_data  = grant_q ? build_cmd(1'b1, 4'(wr_req_len), 26'(wr_req_addr))
                             : build_cmd(1'b0, 4'(rd_req_len), 26'(rd_req_addr));
        fifo_wr_en = ~fifo_full;
        if (grant_q) wr_req_ready = ~fifo_full;
        else         rd_req_ready = ~fifo_full;
        if (!fifo_full) begin
          upd = 1'b1;
          if (grant_q) begin
            beats_d = wr_req_len;
            state_d = DATA;
          end else begin
            state_d = ARB;
          end
        end
      end
      DATA: begin
        fifo_data     = wr_data;
        wr_data_ready = ~fifo_full;
        fifo_wr_en    = wr_data_valid & ~fifo_full;
        if (wr_data_valid && !fifo_full) begin
          if (beats_q == '0) state_d = ARB;
          else               beats_d = beats_q - LEN_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign busy     = (state_q != ARB);
  assign grant_wr = grant_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: expected FIFO words are queued when
// stimulus is issued and checked by a monitor on every push.
module tb_sdram_cmd_arbiter;

  localparam int ADDR_W = 24;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 32;

  logic              wr_clk = 1'b0;
  logic              reset_n;
  logic              wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [LEN_W-1:0]  wr_req_len;
  logic              wr_data_valid, wr_data_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [LEN_W-1:0]  rd_req_len;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_data;
  logic              busy, grant_wr;

  sdram_cmd_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .wr_clk        (wr_clk),
    .reset_n       (reset_n),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_len    (wr_req_len),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_data       (wr_data),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_req_len    (rd_req_len),
    .fifo_full     (fifo_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data     (fifo_data),
    .busy          (busy),
    .grant_wr      (grant_wr)
  );

  always #5 wr_clk = ~wr_clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          push_cnt = 0;
  int          rd_rdy_cnt = 0;
  int          wr_rdy_cnt = 0;

  function automatic logic [31:0] exp_cmd(input logic is_wr, input logic [3:0] len,
                                          input logic [23:0] addr);
    return {1'b1, is_wr, len, 2'b00, addr};
  endfunction

  // Push monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge wr_clk) begin
    if (reset_n) begin
      if (rd_req_ready) rd_rdy_cnt++;
      if (wr_req_ready) wr_rdy_cnt++;
      if (fifo_wr_en) begin
        logic [31:0] e;
        push_cnt++;
        tests++;
        if (fifo_full) begin
          fails++;
          $display("FAIL push_while_full: fifo_wr_en=1 with fifo_full=1, required no push");
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL push_unexpected: got %h, required no push", fifo_data);
        end else begin
          e = exp_q.pop_front();
          if (fifo_data !== e) begin
            fails++;
            $display("FAIL push_data: got %h, required %h", fifo_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_read(input logic [23:0] a, input logic [3:0] l, input bit push_exp,
                         output bit ok);
    if (push_exp) exp_q.push_back(exp_cmd(1'b0, l, a));
    rd_req_addr  = a;
    rd_req_len   = l;
    rd_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge wr_clk);
      if (rd_req_ready) begin ok = 1'b1; break; end
    end
    tick();
    rd_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [23:0] a, input logic [3:0] l,
                          input logic [31:0] d [16], input bit push_exp, output bit ok);
    if (push_exp) begin
      exp_q.push_back(exp_cmd(1'b1, l, a));
      for (int k = 0; k <= int'(l); k++) exp_q.push_back(d[k]);
    end
    wr_req_addr  = a;
    wr_req_len   = l;
    wr_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge wr_clk);
      if (wr_req_ready) begin ok = 1'b1; break; end
    end
    tick();
    wr_req_valid = 1'b0;
    for (int k = 0; k <= int'(l) && ok; k++) begin
      wr_data       = d[k];
      wr_data_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge wr_clk);
        if (wr_data_ready) begin ok = 1'b1; break; end
      end
      tick();
    end
    wr_data_valid = 1'b0;
  endtask

  task automatic check_ok(input string name, input bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: handshake not seen, required within 200 cycles", name);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (3) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d words left, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {wr_req_valid, wr_data_valid, rd_req_valid, fifo_full} = '0;
    wr_req_addr = '0; wr_req_len = '0; wr_data = '0; rd_req_addr = '0; rd_req_len = '0;
    repeat (3) @(negedge wr_clk);
    tests++;
    if ({fifo_wr_en, busy, wr_req_ready, rd_req_ready, wr_data_ready, grant_wr} !== 6'b0 ||
        fifo_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: en/busy/rdys/grant=%b data=%h, required all 0",
               {fifo_wr_en, busy, wr_req_ready, rd_req_ready, wr_data_ready, grant_wr},
               fifo_data);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge wr_clk);
      tests++;
      if ({fifo_wr_en, busy, wr_req_ready, rd_req_ready, wr_data_ready} !== 5'b0) begin
        fails++;
        $display("FAIL idle_outputs: en/busy/rdys=%b, required 00000",
                 {fifo_wr_en, busy, wr_req_ready, rd_req_ready, wr_data_ready});
      end
    end
  endtask

  task automatic test_read();
    bit ok;
    int p0, r0;
    tick();
    p0 = push_cnt; r0 = rd_rdy_cnt;
    do_read(24'h000100, 4'd3, 1'b1, ok);
    check_ok("read", ok);
    check_drained("read");
    tests++;
    if (push_cnt - p0 != 1 || rd_rdy_cnt - r0 != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL read_counts: pushes=%0d readys=%0d busy=%b, required 1 1 0",
               push_cnt - p0, rd_rdy_cnt - r0, busy);
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [31:0] d [16];
    foreach (d[k]) d[k] = '0;
    d[0] = 32'hAAAA5555;
    d[1] = 32'h00000000;
    tests++;
    if (exp_cmd(1'b1, 4'd1, 24'h0000FF) !== 32'hC40000FF) begin
      fails++;
      $display("FAIL write_cmd_model: got %h, required C40000FF", exp_cmd(1'b1, 4'd1, 24'h0000FF));
    end
    do_write(24'h0000FF, 4'd1, d, 1'b1, ok);
    check_ok("write", ok);
    tests++;
    if (grant_wr !== 1'b1) begin
      fails++;
      $display("FAIL write_grant_hold: grant_wr=%b, required 1", grant_wr);
    end
    check_drained("write");
  endtask

  task automatic test_write_max();
    bit ok;
    int p0;
    logic [31:0] d [16];
    foreach (d[k]) d[k] = $urandom();
    p0 = push_cnt;
    do_write(24'hFFFFFF, 4'd15, d, 1'b1, ok);
    check_ok("write_max", ok);
    check_drained("write_max");
    tests++;
    if (push_cnt - p0 != 17) begin
      fails++;
      $display("FAIL write_max_count: pushes=%0d, required 17", push_cnt - p0);
    end
  endtask

  task automatic test_alternate();
    bit okw0, okw1, okr0, okr1;
    logic [31:0] d0 [16], d1 [16];
    foreach (d0[k]) begin d0[k] = 32'h1000 + k; d1[k] = 32'h2000 + k; end
    // Fresh reset puts last_grant on the read path, so write goes first.
    reset_n = 1'b0; #3; reset_n = 1'b1;
    exp_q.push_back(exp_cmd(1'b1, 4'd1, 24'h000010));
    exp_q.push_back(d0[0]); exp_q.push_back(d0[1]);
    exp_q.push_back(exp_cmd(1'b0, 4'd2, 24'h000020));
    exp_q.push_back(exp_cmd(1'b1, 4'd0, 24'h000030));
    exp_q.push_back(d1[0]);
    exp_q.push_back(exp_cmd(1'b0, 4'd7, 24'h000040));
    tick();
    fork
      begin
        do_write(24'h000010, 4'd1, d0, 1'b0, okw0);
        do_write(24'h000030, 4'd0, d1, 1'b0, okw1);
      end
      begin
        do_read(24'h000020, 4'd2, 1'b0, okr0);
        do_read(24'h000040, 4'd7, 1'b0, okr1);
      end
    join
    check_ok("alt", okw0 & okw1 & okr0 & okr1);
    check_drained("alt");
  endtask

  task automatic test_full_stall();
    bit ok, tmo;
    int p0;
    logic [31:0] d [16];
    foreach (d[k]) d[k] = 32'hB0B0_0000 + k;
    p0 = push_cnt;
    tmo = 1'b0;
    fork
      do_write(24'h00ABCD, 4'd3, d, 1'b1, ok);
      begin
        int i;
        for (i = 0; i < 200; i++) begin
          @(posedge wr_clk);
          if (push_cnt >= p0 + 2) break;
        end
        if (i == 200) tmo = 1'b1;
        #1 fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge wr_clk);
          tests++;
          if (fifo_wr_en !== 1'b0 || wr_data_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_stall: en=%b data_rdy=%b, required 0 0",
                     fifo_wr_en, wr_data_ready);
          end
        end
        @(posedge wr_clk);
        #1 fifo_full = 1'b0;
      end
    join
    check_ok("full", ok & ~tmo);
    check_drained("full");
    tests++;
    if (push_cnt - p0 != 5) begin
      fails++;
      $display("FAIL full_count: pushes=%0d, required 5", push_cnt - p0);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    exp_q.push_back(exp_cmd(1'b1, 4'd3, 24'h000777));
    exp_q.push_back(32'hDEAD0001);
    wr_req_addr = 24'h000777; wr_req_len = 4'd3; wr_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge wr_clk);
      if (wr_req_ready) begin ok = 1'b1; break; end
    end
    tick();
    wr_req_valid = 1'b0;
    wr_data = 32'hDEAD0001; wr_data_valid = 1'b1;
    @(negedge wr_clk);
    tick();
    wr_data_valid = 1'b0;
    wr_data = 32'h12345678;
    @(negedge wr_clk);
    check_ok("midrst", ok);
    tests++;
    if (busy !== 1'b1 || wr_data_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_in_data: busy=%b data_rdy=%b, required 1 1", busy, wr_data_ready);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({fifo_wr_en, busy, wr_req_ready, rd_req_ready, wr_data_ready, grant_wr} !== 6'b0 ||
        fifo_data !== 32'h0) begin
      fails++;
      $display("FAIL midrst_outputs: en/busy/rdys/grant=%b data=%h, required all 0",
               {fifo_wr_en, busy, wr_req_ready, rd_req_ready, wr_data_ready, grant_wr},
               fifo_data);
    end
    @(negedge wr_clk);
    reset_n = 1'b1;
    check_drained("midrst");
    do_read(24'h000555, 4'd0, 1'b1, ok);
    check_ok("midrst_read", ok);
    check_drained("midrst_read");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_write_max();
    test_alternate();
    test_full_stall();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Write-clock-domain scheduler that shares one async command/data FIFO (SDRAM-bound) between two requesters: the AXI write path and the AXI read path.
- Arbitrates round-robin, serializes each grant into the FIFO as one command word, followed by len+1 data beats for writes.
- Pushes only while the FIFO is not full; never drops or duplicates a word.
- Sits between the AXI slave front-end and the async FIFO write port.

Parameters:
ADDR_W, 24, SDRAM word address width; ADDR_W <= 26.
LEN_W, 4, burst length field width; burst = len+1 beats, maximum 16.
DATA_W, 32, FIFO word width; fixed at 32 by the command format.

Ports:
wr_clk  in  1  clock (FIFO write domain)
reset_n  in  1  asynchronous, active-low reset
wr_req_valid  in  1  write command request
wr_req_ready  out  1  write command accepted this cycle
wr_req_addr  in  ADDR_W  write start address
wr_req_len  in  LEN_W  write beats minus 1
wr_data_valid  in  1  write data beat valid
wr_data_ready  out  1  write data beat accepted this cycle
wr_data  in  DATA_W  write data beat
rd_req_valid  in  1  read command request
rd_req_ready  out  1  read command accepted this cycle
rd_req_addr  in  ADDR_W  read start address
rd_req_len  in  LEN_W  read beats minus 1
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO push strobe
fifo_data  out  DATA_W  FIFO push word
busy  out  1  state != ARB
grant_wr  out  1  current or last grant was the write path

Behaviour:
- Reset (asynchronous, active-low):
  - state=ARB, last_grant=RD, beats_left=0.
  - All ready outputs, fifo_wr_en and busy are 0; fifo_data=0; grant_wr=0.
- Command word format:
  - [31:30] op: 2'b10 read, 2'b11 write.
  - [29:26] len.
  - [ADDR_W-1:0] address; all other bits 0.
  - A command word is never all-zero.
- ARB state:
  - No FIFO push.
  - One valid requester: grant it.
  - Both valid: grant the requester that is not last_grant.
  - On grant: latch the grant, go to CMD next cycle. Otherwise stay in ARB.
- CMD state:
  - fifo_data = command word built from the granted requester's live addr/len inputs.
  - Requester must hold valid, addr and len stable until its ready is asserted.
  - fifo_wr_en = ~fifo_full; granted req_ready = ~fifo_full (combinational).
  - On push: last_grant = granted requester.
    - Write: beats_left = len, go to DATA.
    - Read: go to ARB.
  - fifo_full: hold in CMD with no push and no ready.
- DATA state (writes only):
  - fifo_data = wr_data.
  - wr_data_ready = ~fifo_full.
  - fifo_wr_en = wr_data_valid & ~fifo_full.
  - Each accepted beat: beats_left decrements.
  - Beat accepted with beats_left==0: go to ARB.
  - Missing valid or fifo_full stalls without loss.
- Outputs outside their states:
  - wr_data_ready is 0 outside DATA.
  - Both req_ready outputs are 0 outside CMD.
- Throughput: at least one idle ARB cycle between grants.
  - Read: 2 cycles per command.
  - Write of N beats: N+2 cycles when unstalled.
- Simultaneous events:
  - A request arriving during CMD/DATA waits; no preemption.
  - An arrival in ARB with both requesters valid follows the round-robin rule.
- fifo_full toggling mid-burst: only beats pushed while ~fifo_full count.
- Reset mid-burst: returns to ARB immediately, partial burst abandoned; the upstream is reset by the same reset_n.
- grant_wr reflects the latched grant (1 = write path) and holds through ARB until the next grant.
- Widths: beats_left is LEN_W bits; no arithmetic wrap occurs because decrement stops at 0.

Decomposition:
- Package sdram_cmd_pkg:
  - Op codes OP_RD=2'b10, OP_WR=2'b11.
  - Field offsets OP_LSB=30, LEN_LSB=26.
  - State encoding ARB/CMD/DATA.
  - Command-word build function.
- Sub-module rr_arb2: two-request round-robin picker with a last_grant register and an update strobe.

Test Plan:
- Reset then idle, all valids 0 -> fifo_wr_en never 1, busy=0, all readys 0.
- Read request addr=0x000100, len=3 -> exactly one push of 0x8C000100, rd_req_ready pulsed for 1 cycle, back to ARB; no data beats.
- Write addr=0x0000FF, len=1, data 0xAAAA5555 then 0x00000000 -> pushes 0xC40000FF, 0xAAAA5555, 0x00000000 in order.
- Both requests valid continuously after reset -> grants alternate WR, RD, WR, RD (write first because last_grant=RD).
- fifo_full held high for 5 cycles during beat 2 of a len=3 write -> no push or ready while full; 4 data beats total, no duplicates.
- reset_n asserted during DATA with beats_left=2 -> next cycle state=ARB, all outputs 0; a subsequent read runs normally.
